fp8_word_packer: RTL and testbench
==================================

FP8_WORD_PACKER -- requirements
Module: fp8_word_packer

Interface
REQ-001: The block SHALL have parameter LANES, default 4, giving the number of FP8 bytes per output word.
REQ-002: The block SHALL have parameter SAT_CNT_W, default 16, giving the width of the saturation event counter.
REQ-003: clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004: rst_ni  input  1  asynchronous, active-low reset.
REQ-005: in_valid_i  input  1  the input byte is valid.
REQ-006: in_ready_o  output  1  the block accepts the byte this cycle.
REQ-007: in_fp8_i  input  8  FP8 E5M2 byte from the upstream FP32-to-FP8 packer.
REQ-008: in_sat_i  input  1  upstream saturation flag belonging to in_fp8_i.
REQ-009: in_last_i  input  1  the byte closes the current word.
REQ-010: flush_i  input  1  closes a partial word when no byte is presented.
REQ-011: out_valid_o  output  1  the output word is valid.
REQ-012: out_ready_i  input  1  the downstream consumer accepts the word.
REQ-013: out_word_o  output  8*LANES  packed word; lane k occupies bits [8k+7:8k].
REQ-014: out_mask_o  output  LANES  bit k set means lane k holds a real byte.
REQ-015: out_sat_o  output  1  OR of in_sat_i over the bytes in the word.
REQ-016: out_last_o  output  1  the word was closed by in_last_i or flush_i.
REQ-017: sat_clr_i  input  1  synchronous clear of sat_count_o.
REQ-018: sat_count_o  output  SAT_CNT_W  count of accepted bytes with in_sat_i=1.

Function
REQ-019: Input byte transfer SHALL occur on a cycle with in_valid_i=1 and in_ready_o=1; output word transfer SHALL occur on a cycle with out_valid_o=1 and out_ready_i=1.
REQ-020: in_ready_o SHALL equal (!out_valid_o || out_ready_i), a combinational path from out_ready_i that is permitted.
REQ-021: An assembly register and a lane counter cnt (0..LANES-1) SHALL hold the word being built; each accepted byte SHALL be written to lane cnt, setting mask bit cnt and ORing its sat flag.
REQ-022: A word SHALL close when the accepted byte has cnt=LANES-1 or in_last_i=1; on close the assembled word, mask, sat and last (=in_last_i) SHALL load the output register, cnt SHALL return to 0, and the assembly register SHALL clear.
REQ-023: Latency SHALL be one cycle: out_valid_o asserts on the cycle after the closing byte is accepted.
REQ-024: Unfilled lanes of a closed partial word SHALL read 0x00 with mask bit 0.
REQ-025: When flush_i=1, in_valid_i=0, in_ready_o=1 and cnt>0, the partial word SHALL close with out_last_o=1; with cnt=0 flush SHALL be a no-op and produce no word.
REQ-026: flush_i SHALL be ignored when in_ready_o=0 or in_valid_i=1; upstream holds it until honoured.
REQ-027: Output register contents SHALL hold stable while out_valid_o=1 and out_ready_i=0.
REQ-028: A word transfer and the load of a new closing word in the same cycle SHALL leave out_valid_o=1 with the new word (back-to-back full throughput: one word per LANES cycles).
REQ-029: out_valid_o SHALL clear after a transfer when no new word loads that cycle.
REQ-030: sat_count_o SHALL increment by 1 per accepted byte with in_sat_i=1 and saturate at 2^SAT_CNT_W-1 without wrap.
REQ-031: sat_clr_i SHALL set sat_count_o to 0 on the next edge and SHALL take priority over a simultaneous increment.

Reset
REQ-032: On rst_ni=0, regardless of the clock, out_valid_o=0, out_word_o=0, out_mask_o=0, out_sat_o=0, out_last_o=0, sat_count_o=0, cnt=0 and the assembly register SHALL clear.
REQ-033: Reset mid-word SHALL discard partially assembled bytes; no word SHALL emerge after reset release until new bytes arrive.
REQ-034: in_ready_o SHALL be 1 during and immediately after reset.

Verification
REQ-035: Bytes 0x3C,0x40,0xBC,0x7B (LANES=4, out_ready_i=1) -> next cycle out_word_o=0x7BBC403C, mask=0xF, last=0, sat=0.
REQ-036: Bytes 0x11, then 0x22 with in_last_i=1 -> out_word_o=0x00002211, mask=0x3, last=1; a following flush_i with cnt=0 produces no word.
REQ-037: Full word held with out_ready_i=0 for 5 cycles -> in_ready_o=0, word stable, held input byte later accepted with no loss or duplication.
REQ-038: Three bytes with in_sat_i=1 -> sat_count_o=3 and out_sat_o=1 on their word; sat_clr_i together with a fourth sat byte -> sat_count_o=0.
REQ-039: SAT_CNT_W=2, five sat bytes -> sat_count_o holds 3.
REQ-040: Two bytes accepted, rst_ni pulsed low -> all outputs 0; then bytes 0x01..0x04 -> out_word_o=0x04030201, mask=0xF.

Source files
------------

// File: rtl/fp8_word_packer.sv
// fp8_word_packer: packs FP8 E5M2 bytes into LANES-wide words with lane mask, saturation OR and saturation event count
// Ports:
//   clk_i, rst_ni                         clock, async active-low reset
//   in_valid_i/in_ready_o, in_fp8_i       byte stream; in_sat_i is its saturation flag, in_last_i closes the word
//   flush_i                               closes a partial word on an idle input cycle
//   out_valid_o/out_ready_i, out_word_o   word stream; out_mask_o marks real lanes, out_sat_o ORs lane sat flags
//   out_last_o                            word was closed by in_last_i or flush_i
//   sat_clr_i, sat_count_o                saturating count of accepted saturated bytes, sync clear
module fp8_word_packer #(
  parameter int LANES     = 4,
  parameter int SAT_CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [7:0]           in_fp8_i,
  input  logic                 in_sat_i,
  input  logic                 in_last_i,
  input  logic                 flush_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [8*LANES-1:0]   out_word_o,
  output logic [LANES-1:0]     out_mask_o,
  output logic                 out_sat_o,
  output logic                 out_last_o,
  input  logic                 sat_clr_i,
  output logic [SAT_CNT_W-1:0] sat_count_o
);
  localparam int W  = 8 * LANES;
  localparam int CW = LANES > 1 ? $clog2(LANES) : 1;
  logic [CW-1:0]        r_cnt;
  logic [W-1:0]         r_asm_word;
  logic [LANES-1:0]     r_asm_mask;
  logic                 r_asm_sat;
  logic                 r_out_valid;
  logic [W-1:0]         r_out_word;
  logic [LANES-1:0]     r_out_mask;
  logic                 r_out_sat;
  logic                 r_out_last;
  logic [SAT_CNT_W-1:0] r_sat_cnt;
  logic                 w_acc;
  logic                 w_flush;
  logic                 w_close;
  logic [W-1:0]         w_word;
  logic [LANES-1:0]     w_mask;
  logic                 w_sat;
  assign in_ready_o  = !r_out_valid || out_ready_i;
  assign w_acc       = in_valid_i && in_ready_o;
  assign w_flush     = flush_i && !in_valid_i && in_ready_o && (r_cnt != '0);
  assign w_close     = w_acc && (r_cnt == CW'(LANES - 1) || in_last_i);
  // assembly contents including the byte accepted this cycle
  assign w_word      = r_asm_word | (w_acc ? W'(in_fp8_i) << (8 * r_cnt) : '0);
  assign w_mask      = r_asm_mask | (w_acc ? LANES'(1) << r_cnt : '0);
  assign w_sat       = r_asm_sat | (w_acc && in_sat_i);
  assign out_valid_o = r_out_valid;
  assign out_word_o  = r_out_word;
  assign out_mask_o  = r_out_mask;
  assign out_sat_o   = r_out_sat;
  assign out_last_o  = r_out_last;
  assign sat_count_o = r_sat_cnt;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt       <= '0;
      r_asm_word  <= '0;
      r_asm_mask  <= '0;
      r_asm_sat   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_word  <= '0;
      r_out_mask  <= '0;
      r_out_sat   <= 1'b0;
      r_out_last  <= 1'b0;
      r_sat_cnt   <= '0;
    end else begin
      if (w_close || w_flush) begin
        r_out_valid <= 1'b1;
        r_out_word  <= w_word;
        r_out_mask  <= w_mask;
        r_out_sat   <= w_sat;
        r_out_last  <= w_flush || in_last_i;
        r_cnt       <= '0;
        r_asm_word  <= '0;
        r_asm_mask  <= '0;
        r_asm_sat   <= 1'b0;
      end else begin
        if (out_ready_i) r_out_valid <= 1'b0;
        if (w_acc) begin
          r_cnt      <= r_cnt + 1'b1;
          r_asm_word <= w_word;
          r_asm_mask <= w_mask;
          r_asm_sat  <= w_sat;
        end
      end
      if (sat_clr_i) r_sat_cnt <= '0;
      else if (w_acc && in_sat_i && r_sat_cnt != {SAT_CNT_W{1'b1}}) r_sat_cnt <= r_sat_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_fp8_word_packer.sv
// tb_fp8_word_packer: directed and random checks of fp8_word_packer against a queue-based model
module tb_fp8_word_packer;
  logic clk, rst_n;
  logic in_valid, in_sat, in_last, flush, out_ready, sat_clr;
  logic [7:0] in_fp8;
  logic in_ready_o, out_valid_o, out_sat_o, out_last_o;
  logic [31:0] out_word_o;
  logic [3:0] out_mask_o;
  logic [15:0] sat_count_o;
  logic in_ready2, out_valid2, out_sat2, out_last2;
  logic [31:0] out_word2;
  logic [3:0] out_mask2;
  logic [1:0] sat_count2;
  int vectors = 0;
  int miscompares = 0;
  bit mv, msat, mlast, psat;
  logic [31:0] mword;
  logic [3:0] mmask;
  int satc, satc2;
  byte unsigned pq[$];
  fp8_word_packer u_dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready_o),
    .in_fp8_i(in_fp8), .in_sat_i(in_sat), .in_last_i(in_last), .flush_i(flush),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready), .out_word_o(out_word_o),
    .out_mask_o(out_mask_o), .out_sat_o(out_sat_o), .out_last_o(out_last_o),
    .sat_clr_i(sat_clr), .sat_count_o(sat_count_o)
  );
  fp8_word_packer #(.LANES(4), .SAT_CNT_W(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready2),
    .in_fp8_i(in_fp8), .in_sat_i(in_sat), .in_last_i(in_last), .flush_i(flush),
    .out_valid_o(out_valid2), .out_ready_i(out_ready), .out_word_o(out_word2),
    .out_mask_o(out_mask2), .out_sat_o(out_sat2), .out_last_o(out_last2),
    .sat_clr_i(sat_clr), .sat_count_o(sat_count2)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_out();
    chk("out_valid", out_valid_o, mv);
    if (mv) begin
      chk("out_word", out_word_o, mword);
      chk("out_mask", out_mask_o, mmask);
      chk("out_sat", out_sat_o, msat);
      chk("out_last", out_last_o, mlast);
    end
    chk("sat_count", sat_count_o, satc);
    chk("sat_count_w2", sat_count2, satc2);
  endtask
  task automatic cyc(input bit v, input bit [7:0] b, input bit s, input bit l, input bit f,
                     input bit ordy, input bit clr);
    bit rdy, acc, fl, cl;
    logic [31:0] w;
    in_valid = v; in_fp8 = b; in_sat = s; in_last = l; flush = f; out_ready = ordy; sat_clr = clr;
    #1;
    rdy = !mv || ordy;
    chk("in_ready", in_ready_o, rdy);
    acc = v && rdy;
    fl = f && !v && rdy && pq.size() > 0;
    if (clr) begin satc = 0; satc2 = 0; end
    else if (acc && s) begin
      satc = satc < 65535 ? satc + 1 : satc;
      satc2 = satc2 < 3 ? satc2 + 1 : satc2;
    end
    if (acc) begin pq.push_back(b); psat |= s; end
    cl = fl || (acc && (pq.size() == 4 || l));
    if (cl) begin
      w = 0;
      foreach (pq[k]) w |= 32'(pq[k]) << (8 * k);
      mword = w;
      mmask = 4'((1 << pq.size()) - 1);
      msat = psat;
      mlast = fl ? 1'b1 : l;
      mv = 1'b1;
      pq.delete();
      psat = 1'b0;
    end else if (ordy) mv = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_out();
  endtask
  task automatic byte_in(input bit [7:0] b, input bit s, input bit l);
    cyc(1'b1, b, s, l, 1'b0, 1'b1, 1'b0);
  endtask
  task automatic do_reset();
    in_valid = 0; flush = 0; sat_clr = 0; in_last = 0; in_sat = 0; out_ready = 1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", out_valid_o, 1'b0);
    chk("rst_word", out_word_o, 32'h0);
    chk("rst_mask", out_mask_o, 4'h0);
    chk("rst_sat", out_sat_o, 1'b0);
    chk("rst_last", out_last_o, 1'b0);
    chk("rst_satcnt", sat_count_o, 16'h0);
    chk("rst_ready", in_ready_o, 1'b1);
    mv = 0; psat = 0; satc = 0; satc2 = 0; pq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_ready", in_ready_o, 1'b1);
    @(negedge clk);
    chk_out();
  endtask
  initial begin
    rst_n = 1'b0; in_valid = 0; in_fp8 = 0; in_sat = 0; in_last = 0; flush = 0;
    out_ready = 1; sat_clr = 0;
    mv = 0; psat = 0; satc = 0; satc2 = 0;
    @(negedge clk);
    do_reset();
    byte_in(8'h3C, 0, 0); byte_in(8'h40, 0, 0); byte_in(8'hBC, 0, 0); byte_in(8'h7B, 0, 0);
    chk("full_word_const", out_word_o, 32'h7BBC403C);
    chk("full_mask_const", out_mask_o, 4'hF);
    cyc(0, 0, 0, 0, 0, 1, 0);
    byte_in(8'h11, 0, 0); byte_in(8'h22, 0, 1);
    chk("partial_word_const", out_word_o, 32'h00002211);
    chk("partial_mask_const", out_mask_o, 4'h3);
    chk("partial_last_const", out_last_o, 1'b1);
    cyc(0, 0, 0, 0, 1, 1, 0);
    chk("empty_flush_novalid", out_valid_o, 1'b0);
    byte_in(8'hA5, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    chk("flush_word_const", out_word_o, 32'h000000A5);
    byte_in(8'h01, 0, 0); byte_in(8'h02, 0, 0); byte_in(8'h03, 0, 0);
    cyc(1, 8'h04, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 8'h55, 0, 0, 0, 0, 0);
    chk("stall_word_const", out_word_o, 32'h04030201);
    cyc(1, 8'h55, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    chk("after_stall_word", out_word_o, 32'h00000055);
    byte_in(8'h7C, 1, 0); byte_in(8'h7C, 1, 0); byte_in(8'h7C, 1, 1);
    chk("sat_cnt3_const", sat_count_o, 16'd3);
    chk("sat_word_const", out_sat_o, 1'b1);
    cyc(1, 8'h7C, 1, 0, 0, 1, 1);
    chk("sat_clr_const", sat_count_o, 16'd0);
    for (int i = 0; i < 5; i++) byte_in(8'hFC, 1, 0);
    chk("sat_w2_const", sat_count2, 2'd3);
    cyc(0, 0, 0, 0, 1, 1, 0);
    byte_in(8'hEE, 0, 0); byte_in(8'hDD, 0, 0);
    do_reset();
    cyc(0, 0, 0, 0, 1, 1, 0);
    chk("post_rst_noword", out_valid_o, 1'b0);
    byte_in(8'h01, 0, 0); byte_in(8'h02, 0, 0); byte_in(8'h03, 0, 0); byte_in(8'h04, 0, 0);
    chk("post_rst_word_const", out_word_o, 32'h04030201);
    chk("post_rst_mask_const", out_mask_o, 4'hF);
    for (int i = 0; i < 600; i++)
      cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
